// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU mode-instruction opcodes,
// the arbiter state type and a mode-instruction decoder.
package alu_pkg;

    localparam logic [7:0] CLR_CMP  = 8'h40;
    localparam logic [7:0] CMP_OFF  = 8'h41;
    localparam logic [7:0] CMP_ON   = 8'h42;
    localparam logic [7:0] SIGN_OFF = 8'h43;
    localparam logic [7:0] SIGN_ON  = 8'h44;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_CAPTURE,
        ST_RESP
    } arbState_t;

    // Mode instructions only reconfigure the ALU and never need a start pulse.
    function automatic logic isModeOp(input logic [7:0] cins);
        return (cins == CLR_CMP) || (cins == CMP_OFF) || (cins == CMP_ON) ||
               (cins == SIGN_OFF) || (cins == SIGN_ON);
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, favouring the requester
// that was not served last (requester 0 first after reset).
module alu_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // Set means requester 1 was served last, so requester 0 wins a tie.
    logic r_lastServed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_lastServed <= 1'b1;
        else if (i_advance)
            r_lastServed <= o_grant[1];
    end

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11)
            o_grant = r_lastServed ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters with round-robin grants.
// Define ALU_ARB_TIMEOUT_EN to add a BUSY watchdog that aborts with rsp_err.
module alu_arbiter #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_req_valid,
    input  logic [15:0] i_req_cins,
    input  logic [15:0] i_req_a,
    input  logic [15:0] i_req_b,
    input  logic [1:0]  i_req_carry,
    output logic [1:0]  o_req_ready,
    output logic [1:0]  o_rsp_valid,
    input  logic [1:0]  i_rsp_ready,
    output logic [7:0]  o_rsp_data,
    output logic        o_rsp_carry,
    output logic        o_rsp_over,
    output logic        o_rsp_cmpo,
    output logic        o_rsp_err,
    output logic        o_alu_start,
    output logic        o_alu_oe,
    output logic        o_alu_carryin,
    output logic [7:0]  o_alu_cins,
    output logic [7:0]  o_alu_a,
    output logic [7:0]  o_alu_b,
    input  logic        i_alu_done,
    input  logic        i_alu_carryout,
    input  logic        i_alu_overout,
    input  logic        i_alu_cmpo,
    input  logic [7:0]  i_alu_aluout
);
    import alu_pkg::*;

    arbState_t  r_state;
    arbState_t  w_nextState;
    logic [1:0] w_grant;
    logic [1:0] r_grant;
    logic       w_accept;
    logic       w_isMode;
    logic       w_timeout;
    logic       w_capErr;
    logic [7:0] r_cins;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_carry;
    logic       r_busyFirst;
    logic [7:0] r_rspData;
    logic       r_rspCarry;
    logic       r_rspOver;
    logic       r_rspCmpo;

    alu_rr_arb u_rrArb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    // Masking with rst keeps req_ready low while reset is held.
    assign w_accept = (r_state == ST_IDLE) && (|i_req_valid) && i_alu_done && !rst;
    assign w_isMode = isModeOp(r_cins);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        o_req_ready = 2'b00;
        o_rsp_valid = 2'b00;
        o_alu_start = 1'b0;
        o_alu_oe    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    o_req_ready = w_grant;
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_alu_start = !w_isMode;
                w_nextState = w_isMode ? ST_CAPTURE : ST_BUSY;
            end
            ST_BUSY: begin
                // done may still be high from the previous op in the first cycle
                if (w_timeout || (!r_busyFirst && i_alu_done))
                    w_nextState = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                o_alu_oe    = 1'b1;
                w_nextState = ST_RESP;
            end
            ST_RESP: begin
                o_rsp_valid = r_grant;
                if (|(i_rsp_ready & r_grant))
                    w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant     <= 2'b00;
            r_cins      <= 8'h00;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_carry     <= 1'b0;
            r_busyFirst <= 1'b0;
            r_rspData   <= 8'h00;
            r_rspCarry  <= 1'b0;
            r_rspOver   <= 1'b0;
            r_rspCmpo   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_grant;
                r_cins  <= w_grant[1] ? i_req_cins[15:8] : i_req_cins[7:0];
                r_a     <= w_grant[1] ? i_req_a[15:8]    : i_req_a[7:0];
                r_b     <= w_grant[1] ? i_req_b[15:8]    : i_req_b[7:0];
                r_carry <= w_grant[1] ? i_req_carry[1]   : i_req_carry[0];
            end
            r_busyFirst <= (r_state == ST_ISSUE);
            if (r_state == ST_CAPTURE) begin
                r_rspData  <= w_capErr ? 8'h00 : i_alu_aluout;
                r_rspCarry <= !w_capErr && i_alu_carryout;
                r_rspOver  <= !w_capErr && i_alu_overout;
                r_rspCmpo  <= !w_capErr && i_alu_cmpo;
            end
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYC + 1) + 1;

    logic [CntW-1:0] r_busyCnt;
    logic            r_timedOut;
    logic            r_rspErr;

    // r_busyCnt holds the number of BUSY cycles already completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busyCnt  <= '0;
            r_timedOut <= 1'b0;
            r_rspErr   <= 1'b0;
        end else begin
            r_busyCnt  <= (r_state == ST_BUSY) ? r_busyCnt + 1'b1 : '0;
            r_timedOut <= w_timeout;
            if (r_state == ST_CAPTURE)
                r_rspErr <= r_timedOut;
        end
    end

    assign w_timeout = (r_state == ST_BUSY) && (r_busyCnt == CntW'(TIMEOUT_CYC));
    assign w_capErr  = r_timedOut;
    assign o_rsp_err = r_rspErr;
`else
    assign w_timeout = 1'b0;
    assign w_capErr  = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    assign o_alu_cins    = (r_state == ST_IDLE) ? 8'h00 : r_cins;
    assign o_alu_a       = (r_state == ST_IDLE) ? 8'h00 : r_a;
    assign o_alu_b       = (r_state == ST_IDLE) ? 8'h00 : r_b;
    assign o_alu_carryin = (r_state == ST_IDLE) ? 1'b0  : r_carry;
    assign o_rsp_data    = r_rspData;
    assign o_rsp_carry   = r_rspCarry;
    assign o_rsp_over    = r_rspOver;
    assign o_rsp_cmpo    = r_rspCmpo;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU.
// The watchdog scenario runs only when ALU_ARB_TIMEOUT_EN is defined.
module tb_alu_arbiter;

    localparam int TbTimeout = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reqValid;
    logic [15:0] reqCins;
    logic [15:0] reqA;
    logic [15:0] reqB;
    logic [1:0]  reqCarry;
    logic [1:0]  reqReady;
    logic [1:0]  rspValid;
    logic [1:0]  rspReady;
    logic [7:0]  rspData;
    logic        rspCarry;
    logic        rspOver;
    logic        rspCmpo;
    logic        rspErr;
    logic        aluStart;
    logic        aluOe;
    logic        aluCarryIn;
    logic [7:0]  aluCins;
    logic [7:0]  aluA;
    logic [7:0]  aluB;
    logic        aluDone     = 1'b1;
    logic        aluCarryOut = 1'b0;
    logic        aluOverOut  = 1'b0;
    logic        aluCmpo     = 1'b0;
    logic [7:0]  aluOut      = 8'h00;
    logic        aluPend     = 1'b0;
    logic [1:0]  aluCnt      = 2'd0;
    logic        aluStuck    = 1'b0;

    int compareCount  = 0;
    int mismatchCount = 0;
    int cyc;
    int starts;
    int oes;
    int readies;
    int rise;
    int errCount;
    logic [23:0] issueWord;

    alu_arbiter #(.TIMEOUT_CYC(TbTimeout)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (reqValid),
        .i_req_cins     (reqCins),
        .i_req_a        (reqA),
        .i_req_b        (reqB),
        .i_req_carry    (reqCarry),
        .o_req_ready    (reqReady),
        .o_rsp_valid    (rspValid),
        .i_rsp_ready    (rspReady),
        .o_rsp_data     (rspData),
        .o_rsp_carry    (rspCarry),
        .o_rsp_over     (rspOver),
        .o_rsp_cmpo     (rspCmpo),
        .o_rsp_err      (rspErr),
        .o_alu_start    (aluStart),
        .o_alu_oe       (aluOe),
        .o_alu_carryin  (aluCarryIn),
        .o_alu_cins     (aluCins),
        .o_alu_a        (aluA),
        .o_alu_b        (aluB),
        .i_alu_done     (aluDone),
        .i_alu_carryout (aluCarryOut),
        .i_alu_overout  (aluOverOut),
        .i_alu_cmpo     (aluCmpo),
        .i_alu_aluout   (aluOut)
    );

    always #5 clk = ~clk;

    // ALU stand-in: 0x01 add, 0x02 subtract, anything else AND; returns
    // {cmpo, overflow, carry, result}.
    function automatic logic [10:0] aluModel(input logic [7:0] cins, input logic [7:0] a,
                                             input logic [7:0] b, input logic cin);
        logic [8:0] r;
        logic       ov;
        r  = {1'b0, a & b};
        ov = 1'b0;
        if (cins == 8'h01) begin
            r  = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            ov = (a[7] == b[7]) && (r[7] != a[7]);
        end else if (cins == 8'h02) begin
            r  = {1'b0, a} - {1'b0, b};
            ov = (a[7] != b[7]) && (r[7] != a[7]);
        end
        return {a == b, ov, r};
    endfunction

    // done stays high one cycle after start, then low for three cycles;
    // aluStuck holds done low indefinitely.
    always @(posedge clk) begin
        if (aluStuck) begin
            aluDone <= 1'b0;
            aluPend <= 1'b0;
        end else if (aluStart) begin
            aluPend <= 1'b1;
            aluCnt  <= 2'd2;
            {aluCmpo, aluOverOut, aluCarryOut, aluOut} <= aluModel(aluCins, aluA, aluB, aluCarryIn);
        end else if (aluPend) begin
            aluDone <= 1'b0;
            aluPend <= 1'b0;
        end else if (aluCnt != 2'd0) begin
            aluCnt <= aluCnt - 2'd1;
        end else begin
            aluDone <= 1'b1;
        end
    end

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one instruction on the given requester's lane and raises its valid.
    task automatic applyStimulus(input int idx, input logic [7:0] cins, input logic [7:0] a,
                                 input logic [7:0] b, input logic carry);
        if (idx == 0) begin
            reqCins[7:0] = cins;
            reqA[7:0]    = a;
            reqB[7:0]    = b;
            reqCarry[0]  = carry;
            reqValid[0]  = 1'b1;
        end else begin
            reqCins[15:8] = cins;
            reqA[15:8]    = a;
            reqB[15:8]    = b;
            reqCarry[1]   = carry;
            reqValid[1]   = 1'b1;
        end
    endtask

    // Called during an IDLE cycle: checks the accept pulse, then drops the
    // accepted valid just after the accepting edge.
    task automatic acceptOne(input logic [1:0] who, input string tag);
        #1;
        checkOutput(tag, 32'(reqReady), 32'(who));
        @(posedge clk);
        #1;
        reqValid = reqValid & ~who;
    endtask

    // Steps negedges from the ISSUE cycle (index 1) until rsp_valid equals who,
    // recording start/oe/req_ready activity and the cycle alu_done rose.
    task automatic runUntilRsp(input logic [1:0] who, input int bound);
        logic prevDone;
        cyc = -1; starts = 0; oes = 0; readies = 0; rise = -1;
        issueWord = 24'h0;
        prevDone = aluDone;
        for (int i = 1; i <= bound && cyc < 0; i++) begin
            @(negedge clk);
            if (i == 1) issueWord = {aluCins, aluA, aluB};
            starts += int'(aluStart);
            oes    += int'(aluOe);
            if (reqReady != 2'b00) readies++;
            if (aluDone && !prevDone && rise < 0) rise = i;
            prevDone = aluDone;
            if (rspValid == who) cyc = i;
        end
    endtask

    task automatic releaseRsp(input logic [1:0] who);
        rspReady = who;
        @(posedge clk);
        #1;
        rspReady = 2'b00;
    endtask

    initial begin
        rst = 1'b1; reqValid = 2'b00; reqCins = 16'h0; reqA = 16'h0; reqB = 16'h0;
        reqCarry = 2'b00; rspReady = 2'b00;

        // Reset state, including a request held during reset with done high.
        applyStimulus(0, 8'h01, 8'h05, 8'h03, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rstReqReady", 32'(reqReady), 'h0);
        checkOutput("rstRspValid", 32'(rspValid), 'h0);
        checkOutput("rstAluStart", 32'(aluStart), 'h0);
        checkOutput("rstAluOe", 32'(aluOe), 'h0);
        checkOutput("rstAluCins", 32'(aluCins), 'h0);
        checkOutput("rstPayload", 32'({rspCarry, rspOver, rspCmpo, rspErr, rspData}), 'h0);

        // First grant must wait for alu_done after reset is released.
        aluStuck = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("waitDoneReqReady", 32'(reqReady), 'h0);
        aluStuck = 1'b0;
        @(negedge clk);

        // Single add from requester 0.
        acceptOne(2'b01, "addReqReady");
        runUntilRsp(2'b01, 20);
        checkOutput("addRspArrived", 32'(cyc > 0), 'h1);
        checkOutput("addIssueOperands", 32'(issueWord), 'h010503);
        checkOutput("addStartPulses", starts, 1);
        checkOutput("addDoneToRsp", cyc - rise, 2);
        checkOutput("addOePulses", oes, 1);
        checkOutput("addPayload", 32'({rspCarry, rspOver, rspCmpo, rspErr, rspData}), 'h008);

        // Backpressure with requester 1 pending and a stray rsp_ready on index 1.
        applyStimulus(1, 8'h02, 8'h10, 8'h20, 1'b0);
        rspReady = 2'b10;
        errCount = 0;
        readies  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rspValid != 2'b01 || rspData != 8'h08) errCount++;
            if (reqReady != 2'b00) readies++;
        end
        checkOutput("bpPayloadStable", errCount, 0);
        checkOutput("bpNoReqReady", readies, 0);
        releaseRsp(2'b01);

        // Pending request accepted in the first IDLE cycle.
        acceptOne(2'b10, "b2bReqReady");
        runUntilRsp(2'b10, 20);
        checkOutput("subRspArrived", 32'(cyc > 0), 'h1);
        checkOutput("subIssueOperands", 32'(issueWord), 'h021020);
        checkOutput("subPayload", 32'({rspCarry, rspOver, rspCmpo, rspErr, rspData}), 'h8F0);
        releaseRsp(2'b10);

        // Reset while BUSY abandons the operation.
        applyStimulus(0, 8'h01, 8'h7F, 8'h01, 1'b0);
        acceptOne(2'b01, "rbReqReady");
        repeat (3) @(negedge clk);
        checkOutput("rbBusyCins", 32'(aluCins), 'h01);
        rst = 1'b1;
        #1;
        checkOutput("rbRspValid", 32'(rspValid), 'h0);
        checkOutput("rbAluStart", 32'(aluStart), 'h0);
        checkOutput("rbAluCins", 32'(aluCins), 'h0);
        checkOutput("rbPayload", 32'({rspCarry, rspOver, rspCmpo, rspErr, rspData}), 'h0);
        @(negedge clk);
        rst = 1'b0;
        errCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rspValid != 2'b00 || aluOe) errCount++;
        end
        checkOutput("rbNoResponse", errCount, 0);

        // Contention right after reset: requester 0 first, then requester 1.
        applyStimulus(0, 8'h01, 8'h7F, 8'h01, 1'b0);
        applyStimulus(1, 8'h01, 8'h22, 8'h22, 1'b0);
        acceptOne(2'b01, "ctnFirstGrant");
        runUntilRsp(2'b01, 20);
        checkOutput("ctnR0Arrived", 32'(cyc > 0), 'h1);
        checkOutput("ctnR0Payload", 32'({rspCarry, rspOver, rspCmpo, rspErr, rspData}), 'h480);
        checkOutput("ctnNoEarlyGrant", readies, 0);
        releaseRsp(2'b01);
        acceptOne(2'b10, "ctnSecondGrant");
        runUntilRsp(2'b10, 20);
        checkOutput("ctnR1Arrived", 32'(cyc > 0), 'h1);
        checkOutput("ctnR1Payload", 32'({rspCarry, rspOver, rspCmpo, rspErr, rspData}), 'h244);
        releaseRsp(2'b10);

        // Mode instruction: no start pulse, response in the third cycle.
        applyStimulus(1, 8'h44, 8'h00, 8'h00, 1'b0);
        acceptOne(2'b10, "modeReqReady");
        runUntilRsp(2'b10, 10);
        checkOutput("modeRspCycle", cyc, 3);
        checkOutput("modeStartPulses", starts, 0);
        checkOutput("modeOePulses", oes, 1);
        releaseRsp(2'b10);

        // A request withdrawn while done is low is never granted.
        aluStuck = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(0, 8'h01, 8'h01, 8'h01, 1'b0);
        errCount = 0;
        repeat (2) begin
            @(negedge clk);
            if (reqReady != 2'b00) errCount++;
        end
        reqValid = 2'b00;
        aluStuck = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (reqReady != 2'b00 || aluStart || aluCins != 8'h00) errCount++;
        end
        checkOutput("dropNoGrant", errCount, 0);

`ifdef ALU_ARB_TIMEOUT_EN
        // Watchdog: done stuck low forces an error response.
        applyStimulus(0, 8'h01, 8'h09, 8'h09, 1'b0);
        acceptOne(2'b01, "toReqReady");
        aluStuck = 1'b1;
        runUntilRsp(2'b01, TbTimeout + 10);
        checkOutput("toRspCycle", cyc, TbTimeout + 4);
        checkOutput("toPayload", 32'({rspCarry, rspOver, rspCmpo, rspErr, rspData}), 'h100);
        releaseRsp(2'b01);
        aluStuck = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15: BUSY cycles before a watchdog abort (used only when ALU_ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have clk  input  1  clock; rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have req_valid  input  2  per-requester request, index 0/1.
REQ-004 SHALL have req_cins, req_a, req_b  input  16 each  per-requester ALU instruction and operands; bits [7:0] are requester 0, bits [15:8] are requester 1.
REQ-005 SHALL have req_carry  input  2  per-requester carry-in.
REQ-006 SHALL have req_ready  output  2  one-cycle accept pulse, at most one bit set.
REQ-007 SHALL have rsp_valid  output  2  result valid to the granted requester.
REQ-008 SHALL have rsp_ready  input  2  result taken.
REQ-009 SHALL have rsp_data  output  8; rsp_carry, rsp_over, rsp_cmpo, rsp_err  output  1 each  shared response payload.
REQ-010 SHALL have ALU port alu_start, alu_oe, alu_carryin  output  1; alu_cins, alu_a, alu_b  output  8; alu_done, alu_carryout, alu_overout, alu_cmpo  input  1; alu_aluout  input  8.

Function
REQ-011 SHALL implement an FSM with states IDLE, ISSUE, BUSY, CAPTURE and RESP.
REQ-012 IDLE: when any req_valid is set and alu_done=1, SHALL grant by round-robin (priority to the requester not served last; requester 0 first after reset), pulse req_ready for that requester, latch its cins/a/b/carry, and go to ISSUE.
REQ-013 ISSUE (1 cycle): SHALL drive the latched alu_cins/a/b/carryin; alu_start=1 unless cins is a mode instruction (0x40..0x44), in which case alu_start=0 and the next state is CAPTURE.
REQ-014 BUSY: SHALL hold alu_start=0, keep alu_cins/a/b/carryin stable, ignore alu_done in the first BUSY cycle, and go to CAPTURE on the first later cycle with alu_done=1.
REQ-015 CAPTURE (1 cycle): SHALL drive alu_oe=1 and register alu_aluout, alu_carryout, alu_overout and alu_cmpo into the rsp_* outputs.
REQ-016 RESP: SHALL hold rsp_valid[g]=1 for granted requester g with a stable payload until rsp_ready[g]=1, then return to IDLE; rsp_ready on the other index SHALL be ignored.
REQ-017 Back-to-back: a request pending in IDLE SHALL be accepted in that same IDLE cycle; there are no idle bubbles beyond IDLE itself.
REQ-018 Simultaneous req_valid=2'b11: exactly one grant; the loser SHALL be granted on the next IDLE visit.
REQ-019 A requester that drops req_valid before req_ready SHALL NOT be granted.
REQ-020 alu_oe SHALL be 0 outside CAPTURE; alu_cins SHALL be 0x00 in IDLE.

Reset
REQ-021 On rst the FSM SHALL go to IDLE, all outputs to 0, and the round-robin pointer to favour requester 0; reset mid-operation SHALL abandon the operation with no rsp_valid.
REQ-022 After rst deassertion, the first grant SHALL wait for alu_done=1.

Configuration
REQ-023 With ALU_ARB_TIMEOUT_EN defined, a BUSY counter exceeding TIMEOUT_CYC SHALL force CAPTURE with rsp_err=1 and rsp_data=0x00.
REQ-024 Without ALU_ARB_TIMEOUT_EN, there SHALL be no counter, rsp_err SHALL be tied to 0, and BUSY waits indefinitely.

Structure
REQ-025 Package alu_pkg SHALL hold the mode constants (CLR_CMP 0x40, CMP_OFF 0x41, CMP_ON 0x42, SIGN_OFF 0x43, SIGN_ON 0x44) and the arbiter state enum.
REQ-026 Round-robin grant logic SHALL be sub-module alu_rr_arb: 2 requests, a last-served pointer, and one-hot grant.

Verification
REQ-027 Single add: r0 cins=ADD, a=0x05, b=0x03 -> one alu_start pulse, rsp_valid[0] set 2 cycles after alu_done rises, rsp_data=0x08.
REQ-028 Contention: both requesters valid in the same cycle after reset -> r0 granted first, r1 granted on the next IDLE, and r1's response follows r0's.
REQ-029 Mode op: r1 cins=0x44 -> alu_start never asserted and rsp_valid[1] within 3 cycles.
REQ-030 Backpressure: hold rsp_ready=0 for 5 cycles -> payload stable and no new req_ready pulse.
REQ-031 Reset in BUSY -> outputs 0, no response, next request served normally.
REQ-032 Timeout (macro on, alu_done stuck 0) -> rsp_err=1 after TIMEOUT_CYC+1 BUSY cycles.
